// File: rtl/vga_timing_ctrl.sv
`timescale 1ns/1ps
// vga_timing_ctrl: 640x480@60 VGA timing generator with pixel clock-enable.
//
// Optional feature macro: VGA_TEST_PATTERN_EN (adds test_mode colour-bar source).
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   test_mode    (VGA_TEST_PATTERN_EN only) 1 = internal colour bars replace rgb_in
//   rgb_in       colour for current pix_x/pix_y, R[11:8] G[7:4] B[3:0]
//   pix_x/pix_y  current coordinate, 0 when blanked (combinational from counters)
//   pix_valid    counters inside the active region
//   pix_ce       pixel-rate enable, one clk wide
//   hsync/vsync  active-low sync, registered
//   vga_r/g/b    registered colour pins with blanking applied
//   frame_start  one-clk pulse after pixel (0,0) is processed
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
  output logic        pix_ce,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;
  logic             active;
  logic [11:0]      colour_src;

  // Pixel enable and active-region decode straight from the counter registers
  assign pix_ce    = (div_cnt_q == DIV_LAST);
  assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign pix_valid = active;
  assign pix_x     = active ? h_cnt_q : 10'd0;
  assign pix_y     = active ? v_cnt_q[8:0] : 9'd0;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar_idx;
  logic [11:0] bar_rgb;

  // Eight 80-pixel vertical colour bars
  always_comb begin
    bar_idx = 3'(h_cnt_q / 10'd80);
    bar_rgb = 12'h000;
    case (bar_idx)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  assign colour_src = test_mode ? bar_rgb : rgb_in;
`else
  assign colour_src = rgb_in;
`endif

  // Next-state: counters advance and pins update only on pix_ce, using pre-advance counts
  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;

    if (pix_ce) begin
      div_cnt_d     = '0;
      rgb_d         = active ? colour_src : 12'h000;
      hsync_d       = ~((h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E));
      vsync_d       = ~((v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E));
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // State registers; reset aborts any frame in progress and releases sync
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      rgb_q         <= 12'h000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
`timescale 1ns/1ps
// Bench for vga_timing_ctrl using a reduced timing raster so full frames are short.
module tb_vga_timing_ctrl;

  localparam int CD = 4;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 11

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // DUT with CLK_DIV = 4
  logic        rst4_n, tm4;
  logic [11:0] rgb4;
  logic [9:0]  pix_x4;
  logic [8:0]  pix_y4;
  logic        pv4, pce4, hs4, vs4, fs4;
  logic [3:0]  r4, g4, b4;

  // DUT with CLK_DIV = 1
  logic        rst1_n, tm1;
  logic [11:0] rgb1;
  logic [9:0]  pix_x1;
  logic [8:0]  pix_y1;
  logic        pv1, pce1, hs1, vs1, fs1;
  logic [3:0]  r1, g1, b1;

  vga_timing_ctrl #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut4 (
    .clk(clk), .rst_n(rst4_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm4),
`endif
    .rgb_in(rgb4), .pix_x(pix_x4), .pix_y(pix_y4), .pix_valid(pv4), .pix_ce(pce4),
    .hsync(hs4), .vsync(vs4), .vga_r(r4), .vga_g(g4), .vga_b(b4), .frame_start(fs4));

  vga_timing_ctrl #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm1),
`endif
    .rgb_in(rgb1), .pix_x(pix_x1), .pix_y(pix_y1), .pix_valid(pv1), .pix_ce(pce1),
    .hsync(hs1), .vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1));

  // Reference raster model for the CLK_DIV = 4 DUT
  logic [1:0]  m_div;
  logic [9:0]  m_h, m_v;
  logic        m_fs, m_new;
  logic        m_pce, m_act, m_hs, m_vs;
  logic [13:0] sb[$];

  assign m_pce = (m_div == 2'(CD - 1));
  assign m_act = (m_h < 10'(HA)) && (m_v < 10'(VA));
  assign m_hs  = ~((m_h >= 10'(HA + HF)) && (m_h < 10'(HA + HF + HS)));
  assign m_vs  = ~((m_v >= 10'(VA + VF)) && (m_v < 10'(VA + VF + VS)));

  always @(posedge clk) begin
    if (!rst4_n) begin
      m_div <= '0; m_h <= '0; m_v <= '0; m_fs <= 1'b0; m_new <= 1'b0;
      sb.delete();
    end else begin
      m_new <= m_pce;
      m_fs  <= m_pce && (m_h == 10'd0) && (m_v == 10'd0);
      if (m_pce) begin
        m_div <= '0;
        sb.push_back({(m_act ? rgb4 : 12'h000), m_hs, m_vs});
        if (m_h == 10'(HT - 1)) begin
          m_h <= '0;
          m_v <= (m_v == 10'(VT - 1)) ? 10'd0 : m_v + 10'd1;
        end else begin
          m_h <= m_h + 10'd1;
        end
      end else begin
        m_div <= m_div + 2'd1;
      end
    end
  end

  // rgb_in stimulus: pattern only in the sampling cycle, noise otherwise
  initial begin
    forever begin
      @(negedge clk);
      if (m_pce && m_act) rgb4 = {m_h[3:0], m_v[3:0], 4'hA};
      else if (m_pce)     rgb4 = 12'h000;
      else                rgb4 = 12'($urandom);
    end
  end

  // Waits for a selected output to reach a level; n = -1 on timeout
  task automatic wait_sig(input int sel, input logic lvl, input int limit, output int n);
    logic s;
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      case (sel)
        0: s = hs4;
        1: s = vs4;
        2: s = fs4;
        3: s = hs1;
        default: s = vs1;
      endcase
      if (s === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst4_n = 1'b0; rst1_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++; if ({hs4, vs4} !== 2'b11) $display("FAIL rst_sync4: got %b exp 11", {hs4, vs4}); else pass_cnt++;
      total_cnt++; if ({r4, g4, b4} !== 12'h000) $display("FAIL rst_rgb4: got %h exp 000", {r4, g4, b4}); else pass_cnt++;
      total_cnt++; if (fs4 !== 1'b0) $display("FAIL rst_fs4: got %b exp 0", fs4); else pass_cnt++;
      total_cnt++; if ({hs1, vs1, fs1} !== 3'b110) $display("FAIL rst_dut1: got %b exp 110", {hs1, vs1, fs1}); else pass_cnt++;
    end
    rst4_n = 1'b1; rst1_n = 1'b1;
    total_cnt++; if ({pce1, pce4, fs1} !== 3'b100) $display("FAIL rel_neg0: got %b exp 100", {pce1, pce4, fs1}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({fs1, pce4} !== 2'b10) $display("FAIL rel_neg1: got %b exp 10", {fs1, pce4}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({fs1, pce4} !== 2'b00) $display("FAIL rel_neg2: got %b exp 00", {fs1, pce4}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({pce4, fs4} !== 2'b10) $display("FAIL first_pce4: got %b exp 10", {pce4, fs4}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (fs4 !== 1'b1) $display("FAIL first_fs4: got %b exp 1", fs4); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (fs4 !== 1'b0) $display("FAIL fs4_width: got %b exp 0", fs4); else pass_cnt++;
  endtask

  task automatic test_hsync();
    int n1, n2;
    wait_sig(0, 1'b1, 200, n1);
    wait_sig(0, 1'b0, 200, n1);
    total_cnt++; if (m_h !== 10'(HA + HF + 1)) $display("FAIL hsync_fall_pos: got h=%0d exp %0d", m_h, HA + HF + 1); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      wait_sig(0, 1'b1, 200, n1);
      total_cnt++; if (n1 !== HS * CD) $display("FAIL hsync_low_clks: got %0d exp %0d", n1, HS * CD); else pass_cnt++;
      wait_sig(0, 1'b0, 200, n2);
      total_cnt++; if (n1 + n2 !== HT * CD) $display("FAIL line_period: got %0d exp %0d", n1 + n2, HT * CD); else pass_cnt++;
    end
    wait_sig(3, 1'b1, 100, n1);
    wait_sig(3, 1'b0, 100, n1);
    wait_sig(3, 1'b1, 100, n1);
    total_cnt++; if (n1 !== HS) $display("FAIL hsync1_low_clks: got %0d exp %0d", n1, HS); else pass_cnt++;
    wait_sig(3, 1'b0, 100, n2);
    total_cnt++; if (n1 + n2 !== HT) $display("FAIL line1_period: got %0d exp %0d", n1 + n2, HT); else pass_cnt++;
  endtask

  task automatic test_frames();
    int n1, n2, fsc;
    wait_sig(1, 1'b1, 3000, n1);
    wait_sig(1, 1'b0, 3000, n1);
    total_cnt++; if (m_v !== 10'(VA + VF)) $display("FAIL vsync_fall_line: got v=%0d exp %0d", m_v, VA + VF); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      wait_sig(1, 1'b1, 3000, n1);
      total_cnt++; if (n1 !== VS * HT * CD) $display("FAIL vsync_low_clks: got %0d exp %0d", n1, VS * HT * CD); else pass_cnt++;
      fsc = 0; n2 = -1;
      for (int i = 1; i <= 3000; i++) begin
        @(negedge clk);
        if (fs4 === 1'b1) fsc++;
        if (vs4 === 1'b0) begin n2 = i; break; end
      end
      total_cnt++; if (n1 + n2 !== VT * HT * CD) $display("FAIL frame_period: got %0d exp %0d", n1 + n2, VT * HT * CD); else pass_cnt++;
      total_cnt++; if (fsc !== 1) $display("FAIL fs_per_frame: got %0d exp 1", fsc); else pass_cnt++;
    end
    wait_sig(2, 1'b1, 3000, n1);
    wait_sig(2, 1'b0, 5, n1);
    total_cnt++; if (n1 !== 1) $display("FAIL fs_pulse_width: got %0d exp 1", n1); else pass_cnt++;
    wait_sig(2, 1'b1, 3000, n2);
    total_cnt++; if (n1 + n2 !== VT * HT * CD) $display("FAIL fs_period: got %0d exp %0d", n1 + n2, VT * HT * CD); else pass_cnt++;
  endtask

  task automatic test_pixels();
    logic [13:0] e;
    int pops;
    pops = 0;
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < VT * HT * CD; i++) begin
      @(negedge clk);
      total_cnt++; if (pix_x4 !== (m_act ? m_h : 10'd0)) $display("FAIL pix_x: got %0d exp %0d", pix_x4, (m_act ? m_h : 10'd0)); else pass_cnt++;
      total_cnt++; if (pix_y4 !== (m_act ? m_v[8:0] : 9'd0)) $display("FAIL pix_y: got %0d exp %0d", pix_y4, (m_act ? m_v[8:0] : 9'd0)); else pass_cnt++;
      total_cnt++; if (pv4 !== m_act) $display("FAIL pix_valid: got %b exp %b", pv4, m_act); else pass_cnt++;
      total_cnt++; if (pce4 !== m_pce) $display("FAIL pix_ce: got %b exp %b", pce4, m_pce); else pass_cnt++;
      total_cnt++; if (fs4 !== m_fs) $display("FAIL frame_start: got %b exp %b", fs4, m_fs); else pass_cnt++;
      if (m_new && sb.size() > 0) begin
        e = sb.pop_front();
        pops++;
        total_cnt++; if ({r4, g4, b4} !== e[13:2]) $display("FAIL pins_rgb: got %h exp %h (h=%0d v=%0d)", {r4, g4, b4}, e[13:2], m_h, m_v); else pass_cnt++;
        total_cnt++; if ({hs4, vs4} !== e[1:0]) $display("FAIL pins_sync: got %b exp %b (h=%0d v=%0d)", {hs4, vs4}, e[1:0], m_h, m_v); else pass_cnt++;
      end
    end
    total_cnt++; if (pops < VT * HT - 1) $display("FAIL sb_pops: got %0d exp >= %0d", pops, VT * HT - 1); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int n;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * VT * HT * CD; i++) begin
      @(negedge clk);
      if (m_h == 10'(HA + HF + 1) && m_v == 10'(VA + VF)) begin found = 1'b1; break; end
    end
    total_cnt++; if (found !== 1'b1) $display("FAIL mid_find: got %b exp 1", found); else pass_cnt++;
    total_cnt++; if ({hs4, vs4} !== 2'b00) $display("FAIL mid_pre_sync: got %b exp 00", {hs4, vs4}); else pass_cnt++;
    rst4_n = 1'b0;
    @(negedge clk);
    rst4_n = 1'b1;
    total_cnt++; if ({hs4, vs4} !== 2'b11) $display("FAIL mid_sync: got %b exp 11", {hs4, vs4}); else pass_cnt++;
    total_cnt++; if ({r4, g4, b4} !== 12'h000) $display("FAIL mid_rgb: got %h exp 000", {r4, g4, b4}); else pass_cnt++;
    total_cnt++; if ({pix_x4, pix_y4, pv4} !== {10'd0, 9'd0, 1'b1}) $display("FAIL mid_coord: got x=%0d y=%0d v=%b exp 0 0 1", pix_x4, pix_y4, pv4); else pass_cnt++;
    total_cnt++; if ({pce4, fs4} !== 2'b00) $display("FAIL mid_pce_fs: got %b exp 00", {pce4, fs4}); else pass_cnt++;
    wait_sig(2, 1'b1, 20, n);
    total_cnt++; if (n !== CD) $display("FAIL mid_fs_delay: got %0d exp %0d", n, CD); else pass_cnt++;
  endtask

  task automatic test_div1();
    int n, zeros;
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pce1 !== 1'b1) zeros++;
    end
    total_cnt++; if (zeros !== 0) $display("FAIL div1_pce_const: got %0d low cycles exp 0", zeros); else pass_cnt++;
    wait_sig(4, 1'b1, 1000, n);
    wait_sig(4, 1'b0, 1000, n);
    wait_sig(3, 1'b0, 100, n);
    total_cnt++; if (n <= 0) $display("FAIL div1_find: got %0d exp >0", n); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({hs1, vs1} !== 2'b00) $display("FAIL div1_pre_sync: got %b exp 00", {hs1, vs1}); else pass_cnt++;
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    total_cnt++; if ({hs1, vs1} !== 2'b11) $display("FAIL div1_mid_sync: got %b exp 11", {hs1, vs1}); else pass_cnt++;
    total_cnt++; if ({r1, g1, b1} !== 12'h000) $display("FAIL div1_mid_rgb: got %h exp 000", {r1, g1, b1}); else pass_cnt++;
    total_cnt++; if ({pix_x1, pix_y1} !== 19'd0) $display("FAIL div1_mid_coord: got x=%0d y=%0d exp 0 0", pix_x1, pix_y1); else pass_cnt++;
    total_cnt++; if ({pce1, fs1} !== 2'b10) $display("FAIL div1_mid_pce_fs: got %b exp 10", {pce1, fs1}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (fs1 !== 1'b1) $display("FAIL div1_fs: got %b exp 1", fs1); else pass_cnt++;
    total_cnt++; if ({r1, g1, b1} !== 12'h5A5) $display("FAIL div1_pix0_rgb: got %h exp 5a5", {r1, g1, b1}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (fs1 !== 1'b0) $display("FAIL div1_fs_width: got %b exp 0", fs1); else pass_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4_n = 1'b0; rst1_n = 1'b0;
    tm4 = 1'b0; tm1 = 1'b0;
    rgb1 = 12'h5A5;
    test_reset();
    test_hsync();
    test_frames();
    test_pixels();
    test_mid_reset();
    test_div1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
